// File: rtl/mem_io_map_if.sv
// rtl/mem_io_map_if.sv - CPU memory port bundle for mem_io_map
// Purpose: groups the CPU-side request/response signals of the memory front-end.
// Ports (signals):
//   mem_addr     CPU address            (master -> slave)
//   mem_data_in  CPU write data         (master -> slave)
//   mem_r_en     read request           (master -> slave)
//   mem_w_en     write request          (master -> slave)
//   mem_rdy      request can be taken   (slave -> master)
//   mem_cplt     one-cycle completion   (slave -> master)
//   mem_data_out read data on mem_cplt  (slave -> master)
interface mem_io_map_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_data_in;
  logic                  mem_r_en;
  logic                  mem_w_en;
  logic                  mem_rdy;
  logic                  mem_cplt;
  logic [DATA_WIDTH-1:0] mem_data_out;

  modport master (
    output mem_addr, mem_data_in, mem_r_en, mem_w_en,
    input  mem_rdy, mem_cplt, mem_data_out
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_r_en, mem_w_en,
    output mem_rdy, mem_cplt, mem_data_out
  );
endinterface

// File: rtl/mem_io_map.sv
// rtl/mem_io_map.sv - MMIO register window in front of the DRAM driver
// Purpose: decodes NUM_REGS read/write registers starting at IO_BASE and answers
//   them locally; every other access is forwarded to the DRAM driver. Only one
//   access is outstanding at a time.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             CPU memory port (slave modport of mem_io_map_if)
//   dram_r_en/w_en  forwarded request, asserted only in the accept cycle
//   dram_rdy        DRAM driver ready (gates mem_rdy)
//   dram_cplt       DRAM completion pulse
//   dram_data_out   DRAM read data
//   io_regs         flattened register contents, register k at [k*DATA_WIDTH +: DATA_WIDTH]
//   io_wr_stb       per-register pulse on the cycle after a write
// Option: define MEM_IO_TIMER_EN to add a read-only 32-bit cycle counter at
//   IO_BASE+NUM_REGS (low half) and IO_BASE+NUM_REGS+1 (high half).
module mem_io_map #(
  parameter int                             ADDR_WIDTH = 16,
  parameter int                             DATA_WIDTH = 16,
  parameter int                             NUM_REGS   = 4,
  parameter logic [ADDR_WIDTH-1:0]          IO_BASE    = 16'h0100,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] REG_RST    = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  mem_io_map_if.slave                    bus,
  output logic                           dram_r_en,
  output logic                           dram_w_en,
  input  logic                           dram_rdy,
  input  logic                           dram_cplt,
  input  logic [DATA_WIDTH-1:0]          dram_data_out,
  output logic [NUM_REGS*DATA_WIDTH-1:0] io_regs,
  output logic [NUM_REGS-1:0]            io_wr_stb
);
  localparam int                    IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] NREG  = ADDR_WIDTH'(NUM_REGS);

  typedef enum logic [1:0] {IDLE, IO_RESP, DRAM_WAIT} state_t;
  state_t state;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  io_cplt_q;

  logic [ADDR_WIDTH-1:0] offset;
  logic [IDX_W-1:0]      idx;
  logic                  rdy;
  logic                  accept;
  logic                  is_read;
  logic                  reg_hit;
  logic                  io_hit;
  logic [DATA_WIDTH-1:0] rd_val;

  // Addresses below IO_BASE wrap to large offsets, so one unsigned compare
  // covers both window bounds.
  assign offset  = bus.mem_addr - IO_BASE;
  assign idx     = offset[IDX_W-1:0];
  assign reg_hit = offset < NREG;

  assign rdy     = (state == IDLE) && dram_rdy;
  assign accept  = rdy && (bus.mem_r_en || bus.mem_w_en);
  // A simultaneous read and write is treated as a read.
  assign is_read = bus.mem_r_en;

`ifdef MEM_IO_TIMER_EN
  localparam logic [ADDR_WIDTH-1:0] NREG1 = ADDR_WIDTH'(NUM_REGS + 1);

  logic [31:0] timer_q;
  logic [15:0] shadow_q;
  logic        tmr_lo_hit;
  logic        tmr_hi_hit;

  assign tmr_lo_hit = (offset == NREG);
  assign tmr_hi_hit = (offset == NREG1);
  assign io_hit     = reg_hit || tmr_lo_hit || tmr_hi_hit;
  assign rd_val     = tmr_lo_hit ? DATA_WIDTH'(timer_q[15:0]) :
                      tmr_hi_hit ? DATA_WIDTH'(shadow_q) : regs_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // Reading the low half freezes the high half so a low-then-high read pair
  // is coherent even if a carry happens in between.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
    end else if (accept && is_read && tmr_lo_hit) begin
      shadow_q <= timer_q[31:16];
    end
  end
`else
  assign io_hit = reg_hit;
  assign rd_val = regs_q[idx];
`endif

  // Forwarded enables exist only in the accept cycle and fall with reset
  // without waiting for a clock.
  assign dram_r_en = rst_n && accept && !io_hit && bus.mem_r_en;
  assign dram_w_en = rst_n && accept && !io_hit && bus.mem_w_en && !bus.mem_r_en;

  assign bus.mem_rdy      = rdy;
  assign bus.mem_cplt     = io_cplt_q || ((state == DRAM_WAIT) && dram_cplt);
  assign bus.mem_data_out = (state == DRAM_WAIT) ? dram_data_out : resp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      io_cplt_q <= 1'b0;
      resp_q    <= '0;
      io_wr_stb <= '0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= REG_RST[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end else begin
      io_cplt_q <= 1'b0;
      resp_q    <= '0;
      io_wr_stb <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (io_hit) begin
              state     <= IO_RESP;
              io_cplt_q <= 1'b1;
              if (is_read) begin
                resp_q <= rd_val;
              end else if (reg_hit) begin
                regs_q[idx]    <= bus.mem_data_in;
                io_wr_stb[idx] <= 1'b1;
              end
            end else begin
              state <= DRAM_WAIT;
            end
          end
        end
        IO_RESP: state <= IDLE;
        DRAM_WAIT: begin
          if (dram_cplt) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_flat
    assign io_regs[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
  end
endmodule

// File: tb/tb_mem_io_map.sv
// tb/tb_mem_io_map.sv - self-checking bench for mem_io_map
// Purpose: directed transactions against a transaction-level model of the
//   register window, compared on every negative clock edge, plus literal checks.
// Ports: none (top-level bench); instantiates mem_io_map_if and mem_io_map.
// Option: define MEM_IO_TIMER_EN to also exercise the cycle counter.
module tb_mem_io_map;
  localparam int          AW      = 16;
  localparam int          DW      = 16;
  localparam int          NR      = 4;
  localparam logic [63:0] RST_VAL = {16'h0000, 16'h0000, 16'h0000, 16'hBEEF};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dram_r_en, dram_w_en, dram_rdy, dram_cplt;
  logic [15:0] dram_data_out;
  logic [63:0] io_regs;
  logic [3:0]  io_wr_stb;

  always #5 clk = ~clk;

  mem_io_map_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_io_map #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR),
    .IO_BASE(16'h0100), .REG_RST(RST_VAL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dram_r_en(dram_r_en), .dram_w_en(dram_w_en), .dram_rdy(dram_rdy),
    .dram_cplt(dram_cplt), .dram_data_out(dram_data_out),
    .io_regs(io_regs), .io_wr_stb(io_wr_stb)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: register array, one outstanding access at most.
  logic [15:0] m_regs [4];
  logic [3:0]  m_stb;
  logic        m_io_done;
  logic [15:0] m_io_data;
  logic        m_dram_busy;
  logic [31:0] m_tick;
  logic [15:0] m_shadow;

  logic [15:0] a;
  logic        e_rdy, e_acc, e_reg, e_tlo, e_thi, e_hit, e_cplt;
  logic [15:0] e_rd, e_data;

  always_comb begin
    a      = bus.mem_addr;
    e_rdy  = !(m_io_done || m_dram_busy) && dram_rdy;
    e_acc  = e_rdy && (bus.mem_r_en || bus.mem_w_en);
    e_reg  = (a >= 16'h0100) && (a < 16'h0104);
    e_tlo  = 1'b0;
    e_thi  = 1'b0;
`ifdef MEM_IO_TIMER_EN
    e_tlo  = (a == 16'h0104);
    e_thi  = (a == 16'h0105);
`endif
    e_hit  = e_reg || e_tlo || e_thi;
    e_rd   = e_tlo ? m_tick[15:0] : e_thi ? m_shadow : e_reg ? m_regs[a[1:0]] : 16'h0000;
    e_cplt = m_io_done || (m_dram_busy && dram_cplt);
    e_data = m_io_done ? m_io_data : dram_data_out;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) m_regs[k] <= RST_VAL[k*16 +: 16];
      m_stb       <= '0;
      m_io_done   <= 1'b0;
      m_io_data   <= '0;
      m_dram_busy <= 1'b0;
      m_tick      <= '0;
      m_shadow    <= '0;
    end else begin
      m_tick    <= m_tick + 32'd1;
      m_stb     <= '0;
      m_io_done <= 1'b0;
      if (m_dram_busy && dram_cplt) m_dram_busy <= 1'b0;
      if (e_acc) begin
        if (e_hit) begin
          m_io_done <= 1'b1;
          m_io_data <= bus.mem_r_en ? e_rd : 16'h0000;
          if (bus.mem_r_en && e_tlo) m_shadow <= m_tick[31:16];
          if (!bus.mem_r_en && e_reg) begin
            m_regs[a[1:0]] <= bus.mem_data_in;
            m_stb[a[1:0]]  <= 1'b1;
          end
        end else begin
          m_dram_busy <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mem_rdy", bus.mem_rdy, e_rdy);
      check("dram_r_en", dram_r_en, rst_n && e_acc && !e_hit && bus.mem_r_en);
      check("dram_w_en", dram_w_en, rst_n && e_acc && !e_hit && bus.mem_w_en && !bus.mem_r_en);
      check("mem_cplt", bus.mem_cplt, e_cplt);
      if (e_cplt) check("mem_data_out", bus.mem_data_out, e_data);
      check("io_regs", io_regs, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
      check("io_wr_stb", io_wr_stb, m_stb);
    end
  end

  // Results of the last txn() call.
  logic [15:0] t_data;
  int          t_lat, t_dr, t_dw, t_rdy_low;
  logic [3:0]  t_stb;
  logic        t_rdy_after;

  task automatic txn(input logic [15:0] addr, input logic r, input logic w,
                     input logic [15:0] wd, input int dlat, input logic [15:0] dd);
    int   n   = 0;
    logic got = 1'b0;
    t_data = '0; t_lat = 0; t_dr = 0; t_dw = 0; t_rdy_low = 0; t_stb = '0;
    while (!bus.mem_rdy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("rdy_wait", n < 50, 1);
    bus.mem_addr = addr; bus.mem_data_in = wd; bus.mem_r_en = r; bus.mem_w_en = w;
    @(negedge clk);
    t_dr += int'(dram_r_en);
    t_dw += int'(dram_w_en);
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      if (c == dlat) begin
        dram_cplt = 1'b1;
        dram_data_out = dd;
      end
      @(negedge clk);
      t_dr += int'(dram_r_en);
      t_dw += int'(dram_w_en);
      t_stb |= io_wr_stb;
      if (!bus.mem_rdy) t_rdy_low++;
      if (bus.mem_cplt) begin
        got = 1'b1;
        t_lat = c;
        t_data = bus.mem_data_out;
      end
      @(posedge clk); #1;
      dram_cplt = 1'b0;
    end
    t_rdy_after = bus.mem_rdy;
    check("txn_done", got, 1);
  endtask

  logic [31:0] prev_v, v;
  logic [15:0] lo, hi;
  int          guard;

  initial begin
    rst_n = 1'b0; dram_rdy = 1'b1; dram_cplt = 1'b0; dram_data_out = '0;
    bus.mem_addr = '0; bus.mem_data_in = '0; bus.mem_r_en = 1'b0; bus.mem_w_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_io_regs", io_regs, RST_VAL);
    check("rst_cplt", bus.mem_cplt, 0);
    check("rst_data", bus.mem_data_out, 0);
    check("rst_stb", io_wr_stb, 0);
    check("rst_dram_r", dram_r_en, 0);
    dram_rdy = 1'b0; #1;
    check("rst_rdy_follow0", bus.mem_rdy, 0);
    dram_rdy = 1'b1; #1;
    check("rst_rdy_follow1", bus.mem_rdy, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    txn(16'h0100, 1, 0, 16'h0000, 0, 16'h0000);
    check("rd100_data", t_data, 16'hBEEF);
    check("rd100_lat", t_lat, 1);
    check("rd100_dram_r", t_dr, 0);
    check("rd100_rdy_low", t_rdy_low, 1);
    check("rd100_rdy_again", t_rdy_after, 1);

    txn(16'h0102, 0, 1, 16'h1234, 0, 16'h0000);
    check("wr102_word2", io_regs[47:32], 16'h1234);
    check("wr102_stb", t_stb, 4'b0100);
    check("wr102_data", t_data, 16'h0000);
    txn(16'h0102, 1, 0, 16'h0000, 0, 16'h0000);
    check("rd102_data", t_data, 16'h1234);

    txn(16'h0200, 1, 0, 16'h0000, 5, 16'hA5A5);
    check("rd200_data", t_data, 16'hA5A5);
    check("rd200_lat", t_lat, 5);
    check("rd200_dram_r", t_dr, 1);
    check("rd200_rdy_low", t_rdy_low, 5);
    check("rd200_rdy_again", t_rdy_after, 1);

    txn(16'h0101, 0, 1, 16'h5A5A, 0, 16'h0000);
    txn(16'h0101, 1, 1, 16'hFFFF, 0, 16'h0000);
    check("rw101_data", t_data, 16'h5A5A);
    check("rw101_stb", t_stb, 4'b0000);
    check("rw101_word1", io_regs[31:16], 16'h5A5A);

    txn(16'h0103, 0, 1, 16'hC0DE, 0, 16'h0000);
    check("wr103_stb", t_stb, 4'b1000);
    check("wr103_word3", io_regs[63:48], 16'hC0DE);

    txn(16'h00FF, 1, 0, 16'h0000, 2, 16'h1111);
    check("rd0ff_dram_r", t_dr, 1);
    check("rd0ff_data", t_data, 16'h1111);
`ifndef MEM_IO_TIMER_EN
    txn(16'h0104, 1, 0, 16'h0000, 1, 16'h2222);
    check("rd104_dram_r", t_dr, 1);
    check("rd104_data", t_data, 16'h2222);
`endif

    txn(16'h0300, 0, 1, 16'h7777, 3, 16'h0000);
    check("wr300_dram_w", t_dw, 1);
    check("wr300_dram_r", t_dr, 0);
    check("wr300_lat", t_lat, 3);

    dram_cplt = 1'b1;
    @(negedge clk);
    check("stray_cplt", bus.mem_cplt, 0);
    @(posedge clk); #1;
    dram_cplt = 1'b0;

    dram_rdy = 1'b0; bus.mem_addr = 16'h0200; bus.mem_r_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("blocked_rdy", bus.mem_rdy, 0);
      check("blocked_dram_r", dram_r_en, 0);
      check("blocked_cplt", bus.mem_cplt, 0);
      @(posedge clk); #1;
    end
    bus.mem_r_en = 1'b0; dram_rdy = 1'b1;

    bus.mem_addr = 16'h0200; bus.mem_r_en = 1'b1;
    @(posedge clk); #1;
    bus.mem_r_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_io_regs", io_regs, RST_VAL);
    check("abort_cplt", bus.mem_cplt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    dram_cplt = 1'b1; dram_data_out = 16'hDEAD;
    @(negedge clk);
    check("abort_late_cplt", bus.mem_cplt, 0);
    @(posedge clk); #1;
    dram_cplt = 1'b0;
    check("abort_io_regs_after", io_regs, RST_VAL);

`ifdef MEM_IO_TIMER_EN
    txn(16'h0104, 0, 1, 16'h9999, 0, 16'h0000);
    check("tmr_wr_lat", t_lat, 1);
    check("tmr_wr_stb", t_stb, 4'b0000);
    guard = 0;
    while (m_tick < 32'h0000FFF6 && guard < 70000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("tmr_wait", guard < 70000, 1);
    prev_v = '0;
    for (int p = 0; p < 6; p++) begin
      txn(16'h0104, 1, 0, 16'h0000, 0, 16'h0000);
      lo = t_data;
      txn(16'h0105, 1, 0, 16'h0000, 0, 16'h0000);
      hi = t_data;
      v = {hi, lo};
      check("tmr_pair_rising", v > prev_v, 1);
      if (p == 0) check("tmr_first_hi", hi, 16'h0000);
      if (p == 5) check("tmr_last_hi", hi, 16'h0001);
      prev_v = v;
    end
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_io_map.md
# mem_io_map

Memory front-end sitting between the CPU memory port and the DRAM driver. It decodes a parametrised window of memory-mapped I/O registers and answers those accesses locally; all other accesses are forwarded to the DRAM driver. It generalises the single hard-wired seven-segment register into NUM_REGS read/write registers with per-register write strobes and explicit transaction tracking, so only one access is outstanding at a time.

## Interface
- ADDR_WIDTH, 16, address width of the CPU and DRAM ports
- DATA_WIDTH, 16, data and register width
- NUM_REGS, 4, number of mapped registers, 1..16
- IO_BASE, 16'h0100, address of register 0; register k is at IO_BASE+k
- REG_RST, 0, flattened reset values, NUM_REGS*DATA_WIDTH bits, register k in bits [k*DATA_WIDTH +: DATA_WIDTH]

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mem_addr  in  ADDR_WIDTH  CPU address
- mem_data_in  in  DATA_WIDTH  CPU write data
- mem_r_en, mem_w_en  in  1  CPU read/write request, sampled when mem_rdy=1
- mem_rdy  out  1  block can accept a request this cycle
- mem_cplt  out  1  one-cycle completion pulse
- mem_data_out  out  DATA_WIDTH  read data, valid while mem_cplt=1
- dram_r_en, dram_w_en  out  1  forwarded request to the DRAM driver
- dram_rdy  in  1  DRAM driver ready
- dram_cplt  in  1  DRAM completion pulse
- dram_data_out  in  DATA_WIDTH  DRAM read data
- io_regs  out  NUM_REGS*DATA_WIDTH  current register contents, flattened
- io_wr_stb  out  NUM_REGS  one-cycle pulse on the cycle after register k is written

Address and write data go to the DRAM driver directly from mem_addr and mem_data_in. They are not routed through this block.

## Operation
- FSM states: IDLE, IO_RESP, DRAM_WAIT. Reset state is IDLE.
- mem_rdy = (state==IDLE) && dram_rdy.
- Accept condition: mem_rdy && (mem_r_en || mem_w_en). If both enables are high, the access is a read and the write is ignored.
- IO hit: IO_BASE <= mem_addr < IO_BASE+NUM_REGS (or the timer window, see Configuration).
  - On a hit, dram_r_en and dram_w_en stay 0.
  - Write: the register is updated at the clock edge. io_wr_stb[k] pulses on the next cycle.
  - Read: the register value is latched into a response register.
  - State goes to IO_RESP.
- IO_RESP lasts one cycle. mem_cplt=1 and mem_data_out = latched read value, or 0 for a write. State then returns to IDLE.
- Miss: dram_r_en/dram_w_en = mem_r_en/mem_w_en, combinationally, only during the accept cycle. State goes to DRAM_WAIT.
- DRAM_WAIT: mem_cplt = dram_cplt and mem_data_out = dram_data_out. On dram_cplt the state returns to IDLE.
- A dram_cplt that arrives outside DRAM_WAIT is ignored: no mem_cplt is generated.
- Register index = mem_addr - IO_BASE, truncated to clog2(NUM_REGS) bits. Only in-window addresses are decoded.

## Timing
- Reset values:
  - state IDLE
  - io_regs = REG_RST
  - io_wr_stb = 0
  - mem_cplt = 0
  - mem_data_out = 0
  - dram_r_en = 0, dram_w_en = 0
  - mem_rdy follows dram_rdy
- IO access latency: accept at cycle N, mem_cplt at N+1, mem_rdy high again at N+2. Back-to-back IO accesses run at one per 2 cycles.
- DRAM access latency: DRAM latency + 0. mem_cplt is the same cycle as dram_cplt, and mem_rdy is high on the next cycle if dram_rdy=1.
- Enable inputs are ignored whenever mem_rdy=0.
- Reset asserted mid-transaction aborts immediately:
  - FSM returns to IDLE.
  - Any pending completion is dropped.
  - Forwarded enables drop asynchronously.

## Configuration
- MEM_IO_TIMER_EN defined: a 32-bit free-running cycle counter is added. It resets to 0 and wraps at 2^32-1 → 0.
  - Read-only, mapped at IO_BASE+NUM_REGS (low 16 bits) and IO_BASE+NUM_REGS+1 (high 16 bits).
  - Reading the low word snapshots the high word into a shadow register. Reading the high word returns the shadow, which gives a coherent 32-bit read.
  - Writes to either address complete normally (mem_cplt pulse) with no effect.
- MEM_IO_TIMER_EN undefined: no counter logic. IO_BASE+NUM_REGS and above are DRAM addresses.

## Test plan
- Reset with REG_RST = {16'h0000, 16'h0000, 16'h0000, 16'hBEEF}, then read 16'h0100 -> mem_cplt one cycle after accept, mem_data_out=16'hBEEF, dram_r_en never asserted.
- Write 16'h1234 to 16'h0102 -> io_regs word 2 = 16'h1234 and io_wr_stb=4'b0100 for one cycle; a following read of 16'h0102 returns 16'h1234.
- Read 16'h0200 with dram_cplt 5 cycles later and dram_data_out=16'hA5A5 -> dram_r_en pulses once, mem_rdy=0 for 5 cycles, mem_cplt with 16'hA5A5.
- mem_r_en=mem_w_en=1 at 16'h0101 -> treated as a read; the register is unchanged and no strobe is generated.
- Drop rst_n during DRAM_WAIT, then release -> mem_cplt stays 0 even when dram_cplt arrives late, and io_regs equals REG_RST.
- With MEM_IO_TIMER_EN: preload the counter near 32'h0000FFFF, then read low then high -> the pair is consistent across the carry, and the high word equals the snapshot even if the counter has advanced.
